fixed_mult_arbiter: RTL and testbench
=====================================

// Module: fixed_mult_arbiter
// PURPOSE
//  Shares one registered fixed-point multiplier between NREQ requesters.
//  - Round-robin arbitration; valid/ready handshake on both sides.
//  - Each requester has one result slot; result returns to its originator.
//  - Sits between per-channel fixed-point datapaths (filters, dot-product
//    units) and a single DSP multiplier, saving DSPs when per-channel
//    multiply rate is below 1/cycle.
// PARAMETERS
//  NREQ       4              number of requesters (2..16)
//  BITS       8              operand/result width, two's complement
//  PRECISION  "FIXED_04_04"  format string; last two chars = fraction bits (F)
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          synchronous, active-high reset
//  req_valid  in   NREQ       requester i has operands
//  req_ready  out  NREQ       one-hot grant; handshake when valid&ready
//  req_a      in   NREQ*BITS  operand a, requester i at [i*BITS +: BITS]
//  req_b      in   NREQ*BITS  operand b, same packing
//  res_valid  out  NREQ       result slot i holds a result
//  res_ready  in   NREQ       requester i consumes its result
//  res_c      out  NREQ*BITS  result for requester i, same packing
// BEHAVIOUR
//  - Reset (clk edge with rst=1):
//    - res_valid=0, res_c=0, in-flight stage invalid.
//    - RR pointer=0; req_ready=0 while rst is high.
//  - busy[i] = in-flight stage tagged i OR res_valid[i].
//    - eligible[i] = req_valid[i] & ~busy[i].
//    - At most one outstanding op per requester.
//  - Grant (combinational):
//    - Lowest eligible index at or after ptr, wrapping NREQ-1 -> 0.
//    - req_ready = one-hot of that index, or 0 if none eligible.
//    - req_ready never depends on res_ready.
//    - Requester must hold a/b stable while valid & ~ready.
//  - Accept cycle T: winner's a,b and id latch into stage 1; ptr <= id+1 mod NREQ.
//  - Stage 1 -> slot: product = a*b (signed, 2*BITS).
//    - c = {product[2B-1], product[B+F-2:F]}.
//    - Truncate toward -inf; overflow wraps (no saturation).
//    - Slot[id] loads at edge T+2; res_valid[id]=1 from T+2 (latency 2).
//  - Slot i clears when res_valid[i]&res_ready[i].
//    - Requester i is eligible again the cycle after the clear.
//    - No same-cycle re-grant.
//  - res_ready[i] with res_valid[i]=0 is ignored.
//  - Throughput: one accept per cycle across requesters.
//  - Idle cycles do not move ptr.
//  - Simultaneous pop of slot i and write to slot j (j != i): both take effect.
//    - A write to slot i while res_valid[i]=1 is impossible by construction.
//  - rst mid-operation: in-flight op and all slot contents discarded.
//    - No res_valid for pre-reset accepts.
//  - Assertions: req_ready one-hot-or-zero; no slot write while res_valid set.
// STRUCTURE
//  - Package fixed_pkg:
//    - function frac_bits(PRECISION).
//    - function fx_trunc(product, BITS, F) shared with other fixed blocks.
//  - Sub-module rr_arbiter #(N): inputs eligible, ptr; outputs one-hot grant and
//    encoded id. Reusable for other shared fixed-point units.
//  - Top: stage-1 register {valid,id,a,b}, slot array, pointer update.
// TESTING (NREQ=4, BITS=8, F=4)
//  - Single op: req0 a=0x18 b=0x20 (1.5*2.0) -> ready same cycle;
//    res_valid[0] two cycles later, res_c[0]=0x30.
//  - Sign: req2 a=0xF0 b=0x28 (-1.0*2.5) -> res_c[2]=0xD8.
//    Overflow: a=0x40 b=0x40 -> 0x00 (wrap).
//  - Fairness: all four valid, res_ready=1 -> grants 0,1,2,3,0... one per cycle;
//    results in same order, each at latency 2.
//  - Backpressure: res_ready[1]=0, req1 valid -> one grant only;
//    req_ready[1] stays 0 until pop; others keep being served.
//  - Reset: assert rst the cycle after an accept -> no res_valid afterwards;
//    ptr=0 so req0 wins first post-reset grant.
//  - Wrap: ptr=3, only req3 and req0 valid -> req3 then req0.

Source files
------------

// File: rtl/fixed_pkg.sv
// Fixed-point helpers shared by blocks that operate on two's-complement Qm.F values.
// frac_bits decodes a "..._NN" format tag; fx_trunc narrows a full product back to operand width.
package fixed_pkg;

    localparam int FX_MAXW = 32;

    // Last two characters of the format tag give the number of fraction bits.
    function automatic int frac_bits(input logic [127:0] fmt);
        return (int'(fmt[15:8]) - 48) * 10 + (int'(fmt[7:0]) - 48);
    endfunction

    // Keep the product sign bit plus the bits just above the fraction point.
    // Dropping the low bits of a two's-complement value truncates toward -inf,
    // and discarding the high bits makes overflow wrap.
    function automatic logic [FX_MAXW-1:0] fx_trunc(
        input logic [2*FX_MAXW-1:0] product,
        input int                   bits,
        input int                   f
    );
        logic [2*FX_MAXW-1:0] sh;
        logic [FX_MAXW-1:0]   r;
        sh = product >> f;
        r  = '0;
        for (int k = 0; k < FX_MAXW; k++) begin
            if (k < bits - 1) begin
                r[k] = sh[k];
            end else if (k == bits - 1) begin
                r[k] = product[2*k+1];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: lowest eligible index at or after ptr, wrapping to 0.
// Latency: combinational. Backpressure: none; the caller decides what an idle cycle means.
// The grant is one-hot or zero; id is the encoded winner and is only meaningful when any=1.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] id,
    output logic          any
);

    logic [N-1:0] upper;
    logic [N-1:0] pick;

    always_comb begin
        upper = '0;
        for (int j = 0; j < N; j++) begin
            upper[j] = eligible[j] && (j >= int'(ptr));
        end
        // Nothing at or above ptr means the search has wrapped to index 0.
        pick  = (|upper) ? upper : eligible;
        grant = '0;
        id    = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (pick[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                id       = IW'(j);
            end
        end
        any = |eligible;
    end

endmodule

// File: rtl/fixed_mult_arbiter.sv
// Shares one registered fixed-point multiplier among NREQ requesters, with a result slot per requester.
// Latency: 2 cycles from accept to res_valid. Backpressure: a requester with an op in flight or an unread slot is not granted.
// req_ready never depends on res_ready.
module fixed_mult_arbiter
    import fixed_pkg::*;
#(
    parameter int             NREQ      = 4,
    parameter int             BITS      = 8,
    parameter logic [127:0]   PRECISION = "FIXED_04_04"
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*BITS-1:0] req_a,
    input  logic [NREQ*BITS-1:0] req_b,
    output logic [NREQ-1:0]      res_valid,
    input  logic [NREQ-1:0]      res_ready,
    output logic [NREQ*BITS-1:0] res_c
);

    localparam int F  = frac_bits(PRECISION);
    localparam int IW = $clog2(NREQ);

    typedef struct packed {
        logic            vld;
        logic [IW-1:0]   id;
        logic [BITS-1:0] a;
        logic [BITS-1:0] b;
    } s1_t;

    s1_t                   s1_q, s1_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic [NREQ-1:0]       slot_vld_q, slot_vld_d;
    logic [NREQ*BITS-1:0]  slot_c_q, slot_c_d;

    logic [NREQ-1:0]       busy;
    logic [NREQ-1:0]       eligible;
    logic [NREQ-1:0]       grant;
    logic [IW-1:0]         gnt_id;
    logic                  gnt_any;
    logic signed [2*BITS-1:0] product;
    logic [FX_MAXW-1:0]    c_full;
    logic [BITS-1:0]       c_res;
    logic                  wr_conflict;

    always_comb begin
        busy = '0;
        for (int i = 0; i < NREQ; i++) begin
            busy[i] = slot_vld_q[i] | (s1_q.vld & (s1_q.id == IW'(i)));
        end
    end

    assign eligible = req_valid & ~busy;

    rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
        .eligible (eligible),
        .ptr      (ptr_q),
        .grant    (grant),
        .id       (gnt_id),
        .any      (gnt_any)
    );

    assign req_ready = rst ? '0 : grant;

    assign product = $signed(s1_q.a) * $signed(s1_q.b);
    assign c_full  = fx_trunc((2*FX_MAXW)'($unsigned(product)), BITS, F);
    assign c_res   = c_full[BITS-1:0];

    always_comb begin
        ptr_d       = ptr_q;
        s1_d        = s1_q;
        s1_d.vld    = gnt_any;
        s1_d.id     = gnt_id;
        slot_vld_d  = slot_vld_q & ~res_ready;
        slot_c_d    = slot_c_q;
        wr_conflict = 1'b0;

        if (gnt_any) begin
            ptr_d = (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                s1_d.a = req_a[i*BITS +: BITS];
                s1_d.b = req_b[i*BITS +: BITS];
            end
        end
        // A pop of one slot and a write to another in the same cycle both land.
        for (int i = 0; i < NREQ; i++) begin
            if (s1_q.vld && (s1_q.id == IW'(i))) begin
                wr_conflict               = slot_vld_q[i];
                slot_vld_d[i]             = 1'b1;
                slot_c_d[i*BITS +: BITS]  = c_res;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            s1_q       <= '0;
            slot_vld_q <= '0;
            slot_c_q   <= '0;
        end else begin
            ptr_q      <= ptr_d;
            s1_q       <= s1_d;
            slot_vld_q <= slot_vld_d;
            slot_c_q   <= slot_c_d;
        end
    end

    assign res_valid = slot_vld_q;
    assign res_c     = slot_c_q;

    assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
    assert property (@(posedge clk) disable iff (rst) !wr_conflict);

endmodule

// File: tb/tb_fixed_mult_arbiter.sv
// Directed bench for fixed_mult_arbiter (NREQ=4, BITS=8, Q4.4): arithmetic table plus
// fairness, backpressure, pointer-wrap and mid-operation reset sequences.
module tb_fixed_mult_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  res_valid;
    logic [3:0]  res_ready;
    logic [31:0] res_c;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
    } vec_t;

    vec_t vecs[8];
    logic [3:0] bp_exp[9];

    always #5 clk = ~clk;

    fixed_mult_arbiter #(
        .NREQ      (4),
        .BITS      (8),
        .PRECISION ("FIXED_04_04")
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_c     (res_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t beyond limit", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // id, a, b, expected c (Q4.4, truncate toward -inf, wrap on overflow)
        vecs[0] = '{0, 8'h18, 8'h20, 8'h30};  //  1.5   *  2.0
        vecs[1] = '{2, 8'hF0, 8'h28, 8'hD8};  // -1.0   *  2.5
        vecs[2] = '{1, 8'h40, 8'h40, 8'h00};  //  4.0   *  4.0   wraps
        vecs[3] = '{3, 8'hE8, 8'hE8, 8'h24};  // -1.5   * -1.5
        vecs[4] = '{1, 8'hFF, 8'h01, 8'hFF};  // -1/16  *  1/16  -> -1/16
        vecs[5] = '{2, 8'h7F, 8'h7F, 8'h70};  // max*max wraps
        vecs[6] = '{0, 8'h80, 8'h80, 8'h00};  // -8 * -8 wraps
        vecs[7] = '{3, 8'h80, 8'h10, 8'h80};  // -8 * 1.0
        bp_exp  = '{4'b0001, 4'b0010, 4'b0000, 4'b0001, 4'b0000,
                    4'b0000, 4'b0001, 4'b0000, 4'b0000};

        rst = 1'b1; req_valid = '1; res_ready = '0; req_a = '0; req_b = '0;
        tick(); #1;
        chk4("ready_in_reset", req_ready, 4'b0000);
        tick();
        rst = 1'b0; req_valid = '0; #1;
        chk4("reset_res_valid", res_valid, 4'b0000);
        chk8("reset_res_c_lo", res_c[7:0], 8'h00);
        chk8("reset_res_c_hi", res_c[31:24], 8'h00);
        chk4("idle_ready", req_ready, 4'b0000);

        foreach (vecs[k]) begin
            tick();
            req_valid = 4'(1 << vecs[k].id);
            set_ops(vecs[k].id, vecs[k].a, vecs[k].b);
            #1;
            chk4($sformatf("vec%0d_grant", k), req_ready, 4'(1 << vecs[k].id));
            tick();
            req_valid = '0; #1;
            chk4($sformatf("vec%0d_inflight", k), res_valid, 4'b0000);
            tick(); #1;
            chk4($sformatf("vec%0d_res_valid", k), res_valid, 4'(1 << vecs[k].id));
            chk8($sformatf("vec%0d_res_c", k), res_c[vecs[k].id*8 +: 8], vecs[k].c);
            res_ready = 4'(1 << vecs[k].id);
            tick();
            res_ready = '0; #1;
            chk4($sformatf("vec%0d_popped", k), res_valid, 4'b0000);
        end

        // Fairness: ptr is 0 here; requester i computes 1.0 * i.0.
        for (int i = 0; i < 4; i++) set_ops(i, 8'h10, 8'(i * 16));
        tick();
        req_valid = '1; res_ready = '1;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (k < 8) chk4($sformatf("fair_grant%0d", k), req_ready, 4'(1 << (k % 4)));
            if (k >= 2) begin
                chk4($sformatf("fair_res_valid%0d", k), res_valid, 4'(1 << ((k - 2) % 4)));
                chk8($sformatf("fair_res_c%0d", k), res_c[((k - 2) % 4)*8 +: 8], 8'(((k - 2) % 4) * 16));
            end
            tick();
        end
        req_valid = '0;
        tick(); tick(); tick();

        // Backpressure on slot 1 with ptr at 2.
        set_ops(0, 8'h10, 8'h10);
        set_ops(1, 8'h20, 8'h10);
        req_valid = 4'b0011; res_ready = 4'b1101;
        for (int k = 0; k < 9; k++) begin
            #1;
            chk4($sformatf("bp_grant%0d", k), req_ready, bp_exp[k]);
            if (k >= 3) chk4($sformatf("bp_hold%0d", k), {3'b000, res_valid[1]}, 4'b0001);
            if (k == 3) chk8("bp_res_c1", res_c[15:8], 8'h20);
            tick();
        end
        res_ready = '1; #1;
        chk4("bp_pop_no_regrant", req_ready, 4'b0001);
        tick(); #1;
        chk4("bp_regrant", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        tick(); tick(); tick();

        // Move ptr to 3, then only req3 and req0 request.
        res_ready = '0;
        set_ops(2, 8'h10, 8'h10);
        req_valid = 4'b0100; #1;
        chk4("wrap_setup", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        tick(); tick(); tick();
        set_ops(3, 8'h10, 8'h20);
        set_ops(0, 8'h10, 8'h30);
        req_valid = 4'b1001; #1;
        chk4("wrap_first", req_ready, 4'b1000);
        tick(); #1;
        chk4("wrap_second", req_ready, 4'b0001);
        tick();
        req_valid = '0; res_ready = '1;
        tick(); tick(); tick();

        // Reset the cycle after an accept; ptr is 1 beforehand.
        set_ops(0, 8'h18, 8'h20);
        req_valid = 4'b0001; #1;
        chk4("prerst_grant", req_ready, 4'b0001);
        tick();
        rst = 1'b1; req_valid = '1; #1;
        chk4("rst_ready_low", req_ready, 4'b0000);
        tick();
        rst = 1'b0; req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk4($sformatf("postrst_no_res%0d", k), res_valid, 4'b0000);
            tick();
        end
        req_valid = '1; #1;
        chk4("postrst_first_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
